// File: rtl/pipe_skid_reg.sv
// Handshaked pipeline register with a two-entry skid buffer, synchronous flush
// and occupancy report. in_ready, out_valid and out_data come straight from flops.
module pipe_skid_reg #(
  parameter int WIDTH      = 32,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // State encoding is {skid_v, main_v}; skid valid without main valid never occurs.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_fire, out_fire;
  logic [1:0]       state;

  assign in_ready  = ~skid_v_q;
  assign out_valid = main_v_q;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign state    = {skid_v_q, main_v_q};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      if (CLEAR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_v_d    = 1'b1;
            main_data_d = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
          end else if (in_fire) begin
            skid_v_d    = 1'b1;
            skid_data_d = in_data;
          end else if (out_fire) begin
            main_v_d = 1'b0;
          end
        end
        ST_FULL: begin
          // Draining the skid entry reopens in_ready one cycle later.
          if (out_fire) begin
            skid_v_d    = 1'b0;
            main_data_d = skid_data_q;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  generate
    if (CLEAR_DATA) begin : g_data_clr
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          main_data_q <= '0;
          skid_data_q <= '0;
        end else begin
          main_data_q <= main_data_d;
          skid_data_q <= skid_data_d;
        end
      end
    end else begin : g_data_hold
      // NOTE: payload registers are left unreset here; the valid bits alone qualify them.
      always_ff @(posedge clk) begin
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
      end
    end
  endgenerate

endmodule
